// File: rtl/axil_sram_if.sv
// AXI4-Lite style bus bundle for the 64-bit SRAM slave.
// Valid/ready semantics: a transfer happens on a rising edge where both are 1; a source
// holding valid keeps its payload stable until that edge, and a sink may raise ready freely.
interface axil_sram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axil_sram.sv
// AXI-Lite 64-bit SRAM slave with fixed access latency and independent read/write FSMs.
// FSM states are exposed on dbg_r_state / dbg_w_state.
module axil_sram #(
  parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000,
  parameter int          DEPTH = 4096,
  parameter int          LAT   = 2
) (
  input  logic        clk,
  input  logic        rst,
  axil_sram_if.slave  bus,
  output logic [1:0]  dbg_r_state,
  output logic [1:0]  dbg_w_state
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);
  localparam logic [1:0] OKAY     = 2'b00;
  localparam logic [1:0] SLVERR   = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;

  logic [63:0] mem [DEPTH];

  function automatic logic [63:0] offset(input logic [31:0] a);
    return {32'h0, a} - BASE;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    return ({32'h0, a} >= BASE) && ((offset(a) >> 3) < 64'(DEPTH));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'(offset(a) >> 3);
  endfunction

  // Read channel
  r_state_e    r_state_q, r_state_d;
  logic [3:0]  r_cnt_q, r_cnt_d;
  logic [31:0] raddr_q, raddr_d;
  logic        rvalid_q, rvalid_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_sample;

  always_comb begin
    r_state_d = r_state_q;
    r_cnt_d   = r_cnt_q;
    raddr_d   = raddr_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_sample  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          raddr_d = bus.araddr;
          if (LAT == 1) begin
            r_sample = 1'b1;
          end else begin
            r_cnt_d   = CNT_LOAD;
            r_state_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (r_cnt_q == 4'd0) r_sample = 1'b1;
        else                 r_cnt_d  = r_cnt_q - 4'd1;
      end
      R_RESP: begin
        if (bus.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    // Sampling reads the array before any same-edge commit lands, so collisions see old data.
    if (r_sample) begin
      r_state_d = R_RESP;
      rvalid_d  = 1'b1;
      if (in_range(raddr_d)) begin
        rdata_d = mem[word_idx(raddr_d)];
        rresp_d = OKAY;
      end else begin
        rdata_d = 64'h0;
        rresp_d = SLVERR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= 4'd0;
      raddr_q   <= 32'h0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 64'h0;
      rresp_q   <= OKAY;
    end else begin
      r_state_q <= r_state_d;
      r_cnt_q   <= r_cnt_d;
      raddr_q   <= raddr_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Write channel
  w_state_e    w_state_q, w_state_d;
  logic [3:0]  w_cnt_q, w_cnt_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        w_commit;

  always_comb begin
    w_state_d = w_state_q;
    w_cnt_d   = w_cnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          awaddr_d = bus.awaddr;
        end
        if (bus.wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = bus.wdata;
          wstrb_d = bus.wstrb;
        end
        if (aw_got_d && w_got_d) begin
          if (LAT == 1) begin
            w_commit = 1'b1;
          end else begin
            w_cnt_d   = CNT_LOAD;
            w_state_d = W_WAIT;
          end
        end
      end
      W_WAIT: begin
        if (w_cnt_q == 4'd0) w_commit = 1'b1;
        else                 w_cnt_d  = w_cnt_q - 4'd1;
      end
      W_RESP: begin
        if (bus.bready) begin
          bvalid_d  = 1'b0;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    if (w_commit) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      bresp_d   = in_range(awaddr_d) ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_cnt_q   <= 4'd0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= 32'h0;
      wdata_q   <= 64'h0;
      wstrb_q   <= 8'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      w_cnt_q   <= w_cnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Byte-merge into the target word; reset on the commit edge cancels the store.
  logic [AW-1:0] w_idx;
  logic [63:0]   w_merged;
  logic          mem_we;

  always_comb begin
    w_idx    = word_idx(awaddr_d);
    w_merged = mem[w_idx];
    for (int i = 0; i < 8; i++) begin
      if (wstrb_d[i]) w_merged[8*i +: 8] = wdata_d[8*i +: 8];
    end
    mem_we = w_commit && in_range(awaddr_d) && !rst;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[w_idx] <= w_merged;
  end

  assign bus.arready = (r_state_q == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.awready = (w_state_q == W_IDLE) && !aw_got_q;
  assign bus.wready  = (w_state_q == W_IDLE) && !w_got_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign dbg_r_state = r_state_q;
  assign dbg_w_state = w_state_q;

endmodule

// File: tb/tb_axil_sram.sv
// Directed bench for axil_sram: reset values, full/partial writes, latency, back-pressure,
// out-of-range accesses, same-edge read/write collision and mid-transaction reset.
module tb_axil_sram;
  localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 2;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_r_state;
  logic [1:0] dbg_w_state;
  int         n_tests = 0;
  int         n_fail  = 0;

  axil_sram_if bus();

  axil_sram #(.BASE(BASE), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_r_state (dbg_r_state),
    .dbg_w_state (dbg_w_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  // Checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [63:0] data,
                          input logic [7:0] strb, output logic [1:0] resp);
    int   k;
    logic a_hs;
    logic w_hs;
    bus.awaddr  = addr;
    bus.wdata   = data;
    bus.wstrb   = strb;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    k = 0;
    while ((bus.awvalid || bus.wvalid) && k < 20) begin
      a_hs = bus.awvalid && bus.awready;
      w_hs = bus.wvalid && bus.wready;
      tick();
      if (a_hs) bus.awvalid = 1'b0;
      if (w_hs) bus.wvalid = 1'b0;
      k++;
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b1;
    k = 0;
    while (!bus.bvalid && k < 20) begin
      tick();
      k++;
    end
    check("write_bvalid_seen", 64'(bus.bvalid), 64'd1);
    resp = bus.bresp;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [63:0] data,
                         output logic [1:0] resp, output int lat);
    int k;
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    k = 0;
    while (!bus.arready && k < 20) begin
      tick();
      k++;
    end
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
  endtask

  // Directed sequence
  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    int          lat;

    rst         = 1'b1;
    bus.araddr  = 32'h0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    bus.awaddr  = 32'h0;
    bus.awvalid = 1'b0;
    bus.wdata   = 64'h0;
    bus.wstrb   = 8'h0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;

    tick();
    tick();
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready",  64'(bus.wready),  64'd1);
    check("rst_rvalid",  64'(bus.rvalid),  64'd0);
    check("rst_bvalid",  64'(bus.bvalid),  64'd0);
    check("rst_rdata",   bus.rdata,        64'd0);
    check("rst_rresp",   64'(bus.rresp),   64'd0);
    check("rst_bresp",   64'(bus.bresp),   64'd0);
    check("rst_dbg_r",   64'(dbg_r_state), 64'd0);
    rst = 1'b0;
    tick();

    // Full write then readback with latency
    do_write(32'h8000_0010, 64'h1122334455667788, 8'hFF, r);
    check("full_wr_bresp", 64'(r), 64'd0);
    do_read(32'h8000_0010, d, r, lat);
    check("full_rd_lat",   64'(lat), 64'd2);
    check("full_rd_data",  d,        64'h1122334455667788);
    check("full_rd_rresp", 64'(r),   64'd0);

    // Partial write, low four lanes only
    do_write(32'h8000_0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, r);
    check("part_wr_bresp", 64'(r), 64'd0);
    do_read(32'h8000_0010, d, r, lat);
    check("part_rd_data", d, 64'h11223344BBBBBBBB);

    // Low address bits are ignored
    do_read(32'h8000_0017, d, r, lat);
    check("unaligned_rd_data", d, 64'h11223344BBBBBBBB);

    // Empty strobe leaves the word alone but still answers OKAY
    do_write(32'h8000_0010, 64'hFFFFFFFFFFFFFFFF, 8'h00, r);
    check("zero_strb_bresp", 64'(r), 64'd0);
    do_read(32'h8000_0010, d, r, lat);
    check("zero_strb_data", d, 64'h11223344BBBBBBBB);

    // w three cycles ahead of aw, response held under back-pressure
    bus.awaddr = 32'h8000_0018;
    bus.wdata  = 64'hCAFEF00DDEADBEEF;
    bus.wstrb  = 8'hFF;
    bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("w_first_wready_low",   64'(bus.wready),  64'd0);
    check("w_first_awready_high", 64'(bus.awready), 64'd1);
    tick();
    tick();
    bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    lat = 0;
    while (!bus.bvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("w_first_b_lat", 64'(lat), 64'd2);
    check("w_first_bresp", 64'(bus.bresp), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("b_hold", 64'({bus.bvalid, bus.bresp}), 64'h4);
    end
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("b_done_bvalid",  64'(bus.bvalid),  64'd0);
    check("b_done_awready", 64'(bus.awready), 64'd1);
    check("b_done_wready",  64'(bus.wready),  64'd1);

    bus.araddr  = 32'h8000_0018;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("r_hold_lat", 64'(lat), 64'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("r_hold_valid", 64'({bus.rvalid, bus.rresp}), 64'h4);
      check("r_hold_data",  bus.rdata, 64'hCAFEF00DDEADBEEF);
    end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("r_done_rvalid",  64'(bus.rvalid),  64'd0);
    check("r_done_arready", 64'(bus.arready), 64'd1);

    // Range boundaries
    do_write(32'h8000_0000, 64'h5A5A5A5A5A5A5A5A, 8'hFF, r);
    check("word0_wr_bresp", 64'(r), 64'd0);
    do_write(32'h8000_7FF8, 64'h0F0E0D0C0B0A0908, 8'hFF, r);
    check("last_wr_bresp", 64'(r), 64'd0);
    do_read(32'h8000_7FF8, d, r, lat);
    check("last_rd_data",  d,      64'h0F0E0D0C0B0A0908);
    check("last_rd_rresp", 64'(r), 64'd0);
    do_read(32'h7FFF_FFF8, d, r, lat);
    check("below_rd_lat",   64'(lat), 64'd2);
    check("below_rd_rresp", 64'(r),   64'd2);
    check("below_rd_data",  d,        64'd0);
    do_write(32'h8000_8000, 64'hDEADDEADDEADDEAD, 8'hFF, r);
    check("above_wr_bresp", 64'(r), 64'd2);
    do_read(32'h8000_8000, d, r, lat);
    check("above_rd_rresp", 64'(r), 64'd2);
    check("above_rd_data",  d,      64'd0);
    do_read(32'h8000_0000, d, r, lat);
    check("word0_untouched", d, 64'h5A5A5A5A5A5A5A5A);

    // Read sample and write commit on the same edge
    bus.araddr  = 32'h8000_0010;
    bus.awaddr  = 32'h8000_0010;
    bus.wdata   = 64'h0102030405060708;
    bus.wstrb   = 8'hFF;
    bus.arvalid = 1'b1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    tick();
    tick();
    check("coll_rvalid", 64'(bus.rvalid), 64'd1);
    check("coll_bvalid", 64'(bus.bvalid), 64'd1);
    check("coll_rdata_old", bus.rdata, 64'h11223344BBBBBBBB);
    check("coll_bresp", 64'(bus.bresp), 64'd0);
    bus.rready = 1'b1;
    bus.bready = 1'b1;
    tick();
    bus.rready = 1'b0;
    bus.bready = 1'b0;
    do_read(32'h8000_0010, d, r, lat);
    check("coll_rd_new", d, 64'h0102030405060708);

    // Reset while both channels are counting down
    bus.araddr  = 32'h8000_0018;
    bus.awaddr  = 32'h8000_0018;
    bus.wdata   = 64'hFFFFFFFFFFFFFFFF;
    bus.wstrb   = 8'hFF;
    bus.arvalid = 1'b1;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("abort_in_w_wait", 64'(dbg_w_state), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_rvalid",  64'(bus.rvalid),  64'd0);
    check("abort_bvalid",  64'(bus.bvalid),  64'd0);
    check("abort_arready", 64'(bus.arready), 64'd1);
    check("abort_awready", 64'(bus.awready), 64'd1);
    check("abort_wready",  64'(bus.wready),  64'd1);
    tick();
    tick();
    tick();
    check("abort_quiet", 64'({bus.rvalid, bus.bvalid}), 64'd0);
    do_read(32'h8000_0018, d, r, lat);
    check("abort_word_kept", d, 64'hCAFEF00DDEADBEEF);
    do_read(32'h8000_0010, d, r, lat);
    check("reset_keeps_array", d, 64'h0102030405060708);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/axil_sram.md
AXIL_SRAM -- requirements
Module: axil_sram

Interface
REQ-001 Parameter: BASE, 64'h0000_0000_8000_0000, byte address of word 0.
REQ-002 Parameter: DEPTH, 4096, number of 64-bit words (power of two).
REQ-003 Parameter: LAT, 2, cycles from address handshake to response valid (1..15).
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: araddr  in  32  read byte address.
REQ-007 Port: arvalid / arready  in / out  1  read address handshake.
REQ-008 Port: rdata  out  64  read data, full aligned doubleword.
REQ-009 Port: rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-010 Port: rvalid / rready  out / in  1  read data handshake.
REQ-011 Port: awaddr  in  32  write byte address.
REQ-012 Port: awvalid / awready  in / out  1  write address handshake.
REQ-013 Port: wdata  in  64  write data, lane-aligned.
REQ-014 Port: wstrb  in  8  byte enables; bit i enables wdata[8i+7:8i].
REQ-015 Port: wvalid / wready  in / out  1  write data handshake.
REQ-016 Port: bresp  out  2  write response, same encoding as rresp.
REQ-017 Port: bvalid / bready  out / in  1  write response handshake.

Function
REQ-018 Handshake completes on a rising edge where valid and ready are both 1; the block never waits for its own valid to be accepted before asserting ready, and never deasserts an asserted rvalid or bvalid before the matching ready.
REQ-019 Word index = (addr - BASE) >> 3; addr[2:0] is ignored; an address is in range iff BASE <= addr < BASE + 8*DEPTH (zero-extended to 64 bits).
REQ-020 Read FSM states: R_IDLE, R_WAIT, R_RESP; arready = 1 only in R_IDLE.
REQ-021 R_IDLE: on ar handshake, latch the address, load counter with LAT-1, go to R_WAIT (if LAT = 1, go directly to R_RESP with data sampled that edge).
REQ-022 R_WAIT: decrement counter each cycle; when it is 0, sample the array into rdata, set rresp, assert rvalid, go to R_RESP; rvalid is first high exactly LAT cycles after the ar handshake edge.
REQ-023 R_RESP: hold rvalid, rdata and rresp stable; on r handshake, deassert rvalid and return to R_IDLE (arready high the following cycle; no back-to-back overlap).
REQ-024 Out-of-range read: rresp = 2'b10, rdata = 64'h0, same latency.
REQ-025 Write FSM states: W_IDLE, W_WAIT, W_RESP; aw and w channels are accepted independently in W_IDLE in any order or the same cycle; awready drops after aw is latched, wready drops after w is latched.
REQ-026 When both aw and w are latched, load counter with LAT-1 and enter W_WAIT; on counter 0, commit the byte-masked write (in range only), set bresp, assert bvalid, enter W_RESP.
REQ-027 W_RESP: hold bvalid and bresp until b handshake, then return to W_IDLE with awready = wready = 1 the next cycle.
REQ-028 Out-of-range write: array unmodified, bresp = 2'b10.
REQ-029 wstrb = 8'h00 to an in-range address: no bytes change, bresp = 2'b00.
REQ-030 Read and write FSMs run concurrently; if a read sample and a write commit hit the same word on the same edge, the read returns the pre-write value.
REQ-031 Counters saturate at zero and never wrap.

Reset
REQ-032 While rst = 1 on a rising edge: both FSMs go to IDLE, counters and latched flags clear; outputs next cycle: arready = 1, awready = 1, wready = 1, rvalid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0.
REQ-033 Reset mid-transaction aborts it without response; a pending write that has not reached its commit edge does not modify the array.
REQ-034 Array contents are not cleared by reset.

Verification
REQ-035 LAT = 2: write 64'h1122334455667788 to 0x80000010, wstrb 8'hFF, then read 0x80000010 -> rvalid 2 cycles after ar handshake, rdata = 64'h1122334455667788, rresp = 0.
REQ-036 Partial write: wstrb 8'h0F, wdata 64'hAAAAAAAABBBBBBBB to the same word -> read returns 64'h11223344BBBBBBBB.
REQ-037 w handshake 3 cycles before aw -> bvalid exactly LAT cycles after the aw handshake, bresp = 0; rready/bready held low 5 cycles -> rvalid/bvalid and data stable throughout.
REQ-038 Read 0x7FFFFFF8 and write 0x80000000 + 8*DEPTH -> rresp = 2'b10, rdata = 0; bresp = 2'b10; array unchanged.
REQ-039 Read and write same word, commit and sample on same edge -> rdata is the old value; a subsequent read returns the new value.
REQ-040 Assert rst during R_WAIT and W_WAIT -> no rvalid/bvalid, all readys 1 next cycle, target word unchanged.
